// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 / data-memory interconnect.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // RISC-V major opcodes of the instructions that reach the data memory.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr_i,
// wrapping modulo N_REQ. Returns a one-hot grant and the winning index.
module rr_arbiter
  import cache_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         mask_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     gnt_any_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] k;

  assign eligible = req_i & ~mask_i;

  // Walk the ring starting at the pointer; the first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    k         = ptr_i;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any_o && eligible[k]) begin
        gnt_any_o   = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = k;
      end
      k = (k == IDX_W'(N_REQ - 1)) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter shared by N_REQ L1 controllers.
// IDLE -> ACCESS (MEM_LAT cycles of mem_en_o) -> RESP (one-cycle ack).
// All outputs are registered. Optional write-snoop pulse in RESP is built
// only when DMEM_ARB_SNOOP_INV_EN is defined; otherwise snoop_* are tied 0.
module dmem_arbiter
  import cache_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              we_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              ack_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          busy_o,
  output logic                          snoop_valid_o,
  output logic [ADDR_W-1:0]             snoop_addr_o,
  output logic [$clog2(N_REQ)-1:0]      snoop_src_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mask_q, mask_d;
  logic               mem_en_q, mem_en_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   sel_oh;
  logic [N_REQ-1:0]   mask_vec;
  logic [N_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  // The requester just acked is blinded for one IDLE cycle while it drops req.
  assign sel_oh   = N_REQ'(1) << sel_q;
  assign mask_vec = mask_q ? sel_oh : '0;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i     (req_i),
    .mask_i    (mask_vec),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  // Next-state and registered-output logic for the access FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = 1'b0;
    mem_en_d = mem_en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = '0;
    ack_d    = '0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          sel_d    = arb_idx;
          we_d     = we_i[arb_idx];
          addr_d   = addr_i[arb_idx];
          wdata_d  = wdata_i[arb_idx];
          gnt_d    = arb_oh;
          mem_en_d = 1'b1;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata_i;
          // Memory outputs are cleared so the bus is quiet outside ACCESS.
          mem_en_d = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          ack_d    = sel_oh;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        mask_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= 1'b0;
      mem_en_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      mem_en_q <= mem_en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;

`ifdef DMEM_ARB_SNOOP_INV_EN
  logic               snp_vld_q, snp_vld_d;
  logic [ADDR_W-1:0]  snp_addr_q, snp_addr_d;
  logic [IDX_W-1:0]   snp_src_q, snp_src_d;

  // Write completion broadcasts the line address so peer L1s can invalidate.
  always_comb begin
    snp_vld_d  = 1'b0;
    snp_addr_d = '0;
    snp_src_d  = '0;
    if (state_q == ACCESS && cnt_q == '0 && we_q) begin
      snp_vld_d  = 1'b1;
      snp_addr_d = addr_q;
      snp_src_d  = sel_q;
    end
  end

  // Snoop pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      snp_vld_q  <= 1'b0;
      snp_addr_q <= '0;
      snp_src_q  <= '0;
    end else begin
      snp_vld_q  <= snp_vld_d;
      snp_addr_q <= snp_addr_d;
      snp_src_q  <= snp_src_d;
    end
  end

  assign snoop_valid_o = snp_vld_q;
  assign snoop_addr_o  = snp_addr_q;
  assign snoop_src_o   = snp_src_q;
`else
  assign snoop_valid_o = 1'b0;
  assign snoop_addr_o  = '0;
  assign snoop_src_o   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grant/ack
// records; a negedge monitor pops and compares whenever gnt_o or ack_o fires.
module tb_dmem_arbiter;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int L       = MEM_LAT;
`ifdef DMEM_ARB_SNOOP_INV_EN
  localparam bit SNP = 1'b1;
`else
  localparam bit SNP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [N_REQ-1:0]             req_i, we_i;
  logic [N_REQ-1:0][ADDR_W-1:0] addr_i;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0]             gnt_o, ack_o;
  logic [DATA_W-1:0]            rdata_o, mem_wdata_o, mem_rdata_i;
  logic                         mem_en_o, mem_we_o, busy_o, snoop_valid_o;
  logic [ADDR_W-1:0]            mem_addr_o, snoop_addr_o;
  logic [0:0]                   snoop_src_o;

  dmem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
    .snoop_valid_o(snoop_valid_o), .snoop_addr_o(snoop_addr_o),
    .snoop_src_o(snoop_src_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= reset;

  // Memory model: 0x04C holds 0xDEADBEEF, every other word reads 0xA5000000|addr.
  always_comb begin
    if (mem_en_o && !mem_we_o)
      mem_rdata_i = (mem_addr_o == 10'h04C) ? 32'hDEADBEEF : (32'hA5000000 | 32'(mem_addr_o));
    else
      mem_rdata_i = 32'h0BAD0BAD;
  end

  typedef struct {
    int               cyc;
    logic [N_REQ-1:0] oh;
    logic [ADDR_W-1:0] addr;
    logic             we;
    logic [DATA_W-1:0] wdata;
  } gexp_t;

  typedef struct {
    int               cyc;
    logic [N_REQ-1:0] oh;
    logic [DATA_W-1:0] rdata;
    logic             sv;
    logic [ADDR_W-1:0] sa;
    logic             ss;
  } aexp_t;

  gexp_t gq[$];
  aexp_t aq[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_g(input int c, input logic [N_REQ-1:0] oh, input logic [ADDR_W-1:0] a,
                        input logic we, input logic [DATA_W-1:0] wd);
    gexp_t e;
    e.cyc = c; e.oh = oh; e.addr = a; e.we = we; e.wdata = wd;
    gq.push_back(e);
  endtask

  task automatic push_a(input int c, input logic [N_REQ-1:0] oh, input logic [DATA_W-1:0] rd,
                        input logic sv, input logic [ADDR_W-1:0] sa, input logic ss);
    aexp_t e;
    e.cyc = c; e.oh = oh; e.rdata = rd; e.sv = sv; e.sa = sa; e.ss = ss;
    aq.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    64'(gnt_o), 0);
    chk({tag, "_ack"},    64'(ack_o), 0);
    chk({tag, "_rdata"},  64'(rdata_o), 0);
    chk({tag, "_mem_en"}, 64'(mem_en_o), 0);
    chk({tag, "_mem_we"}, 64'(mem_we_o), 0);
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 0);
    chk({tag, "_busy"},   64'(busy_o), 0);
    chk({tag, "_snoop_v"}, 64'(snoop_valid_o), 0);
  endtask

  // Monitor: compares every grant/ack against the scoreboard and flags
  // expected events whose cycle passed without the DUT producing them.
  gexp_t ge;
  aexp_t ae;
  int run = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_o != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 0);
        else begin
          ge = gq.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
          chk("gnt_vec", 64'(gnt_o), 64'(ge.oh));
          chk("gnt_mem_en", 64'(mem_en_o), 1);
          chk("gnt_mem_addr", 64'(mem_addr_o), 64'(ge.addr));
          chk("gnt_mem_we", 64'(mem_we_o), 64'(ge.we));
          if (ge.we) chk("gnt_mem_wdata", 64'(mem_wdata_o), 64'(ge.wdata));
          chk("gnt_busy", 64'(busy_o), 1);
        end
      end else if (gq.size() != 0 && cyc > gq[0].cyc) begin
        ge = gq.pop_front();
        chk("gnt_missing", 64'(gnt_o), 64'(ge.oh));
      end

      if (ack_o != '0) begin
        if (aq.size() == 0) chk("ack_unexpected", 64'(ack_o), 0);
        else begin
          ae = aq.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
          chk("ack_vec", 64'(ack_o), 64'(ae.oh));
          chk("ack_rdata", 64'(rdata_o), 64'(ae.rdata));
          chk("ack_mem_en", 64'(mem_en_o), 0);
          chk("ack_busy", 64'(busy_o), 1);
          chk("ack_snoop_v", 64'(snoop_valid_o), 64'(ae.sv));
          chk("ack_snoop_addr", 64'(snoop_addr_o), 64'(ae.sa));
          chk("ack_snoop_src", 64'(snoop_src_o), 64'(ae.ss));
        end
      end else if (aq.size() != 0 && cyc > aq[0].cyc) begin
        ae = aq.pop_front();
        chk("ack_missing", 64'(ack_o), 64'(ae.oh));
      end

      // mem_en_o must stay high for exactly MEM_LAT cycles per access.
      if (rst_seen) run = 0;
      else if (mem_en_o) run++;
      else if (run > 0) begin
        chk("mem_en_len", 64'(run), 64'(MEM_LAT));
        run = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c;
  initial begin
    reset = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;

    // Contention right after reset: 0 wins, then 1, then 0 again with 1 held.
    @(negedge clk);
    c = cyc;
    req_i = 2'b11; we_i = 2'b00; addr_i[0] = 10'h010; addr_i[1] = 10'h020;
    push_g(c + 1,         2'b01, 10'h010, 1'b0, '0);
    push_a(c + 1 + L,     2'b01, 32'hA5000010, 1'b0, '0, 1'b0);
    push_g(c + 3 + L,     2'b10, 10'h020, 1'b0, '0);
    push_a(c + 3 + 2*L,   2'b10, 32'hA5000020, 1'b0, '0, 1'b0);
    push_g(c + 5 + 2*L,   2'b01, 10'h010, 1'b0, '0);
    push_a(c + 5 + 3*L,   2'b01, 32'hA5000010, 1'b0, '0, 1'b0);
    push_g(c + 7 + 3*L,   2'b10, 10'h020, 1'b0, '0);
    push_a(c + 7 + 4*L,   2'b10, 32'hA5000020, 1'b0, '0, 1'b0);
    wait_to(c + 1 + L);   req_i[0] = 1'b0;
    wait_to(c + 3 + 2*L); req_i[0] = 1'b1;
    wait_to(c + 5 + 3*L); req_i[0] = 1'b0;
    wait_to(c + 7 + 4*L); req_i[1] = 1'b0;
    wait_to(c + 10 + 4*L);

    // Single read by requester 0.
    c = cyc;
    req_i = 2'b01; we_i = 2'b00; addr_i[0] = 10'h04C;
    push_g(c + 1,     2'b01, 10'h04C, 1'b0, '0);
    push_a(c + 1 + L, 2'b01, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    wait_to(c + 1 + L); req_i = '0;
    wait_to(c + 4 + L);

    // Write by requester 1: rdata_o keeps the last read value.
    c = cyc;
    req_i = 2'b10; we_i = 2'b10; addr_i[1] = 10'h3FF; wdata_i[1] = 32'h12345678;
    push_g(c + 1,     2'b10, 10'h3FF, 1'b1, 32'h12345678);
    push_a(c + 1 + L, 2'b10, 32'hDEADBEEF, SNP, SNP ? 10'h3FF : 10'h000, SNP);
    wait_to(c + 1 + L); req_i = '0; we_i = '0;
    wait_to(c + 4 + L);

    // Held req: requester 0 stays up past its ack; the masked IDLE cycle
    // must not grant, the following one does.
    c = cyc;
    req_i = 2'b01; we_i = 2'b00; addr_i[0] = 10'h04C;
    push_g(c + 1,       2'b01, 10'h04C, 1'b0, '0);
    push_a(c + 1 + L,   2'b01, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    push_g(c + 4 + L,   2'b01, 10'h04C, 1'b0, '0);
    push_a(c + 4 + 2*L, 2'b01, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    wait_to(c + 4 + 2*L); req_i = '0;
    wait_to(c + 7 + 2*L);

    // Reset during ACCESS: no ack, everything cleared, pointer back to 0.
    c = cyc;
    req_i = 2'b01; addr_i[0] = 10'h04C;
    push_g(c + 1, 2'b01, 10'h04C, 1'b0, '0);
    wait_to(c + 1); reset = 1'b1;
    wait_to(c + 2); reset = 1'b0; req_i = '0;
    chk_all_zero("midreset");
    @(negedge clk);
    c = cyc;
    req_i = 2'b11; addr_i[0] = 10'h04C; addr_i[1] = 10'h020;
    push_g(c + 1,       2'b01, 10'h04C, 1'b0, '0);
    push_a(c + 1 + L,   2'b01, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    push_g(c + 3 + L,   2'b10, 10'h020, 1'b0, '0);
    push_a(c + 3 + 2*L, 2'b10, 32'hA5000020, 1'b0, '0, 1'b0);
    wait_to(c + 1 + L);   req_i[0] = 1'b0;
    wait_to(c + 3 + 2*L); req_i[1] = 1'b0;
    wait_to(c + 6 + 2*L);

    chk("gnt_queue_left", 64'(gq.size()), 0);
    chk("ack_queue_left", 64'(aq.size()), 0);
    chk("final_busy", 64'(busy_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between N_REQ L1 cache controllers in the multicore system.
- Each L1 raises a request on a load miss or a store write-through. The arbiter picks one requester round-robin and drives the memory for MEM_LAT cycles.
- It then returns the read data with a one-cycle ack. Losing L1s stay stalled with req held.

Parameters:
- N_REQ, 2, number of L1 requesters (≥2)
- ADDR_W, 10, memory address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles mem_en_o is held per access (≥1)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_i  in  N_REQ  per-requester access request, held until ack
- we_i  in  N_REQ  1 = write, 0 = read
- addr_i  in  N_REQ×ADDR_W  per-requester address
- wdata_i  in  N_REQ×DATA_W  per-requester write data
- gnt_o  out  N_REQ  one-cycle pulse: request accepted
- ack_o  out  N_REQ  one-cycle pulse: access done; rdata_o valid this cycle
- rdata_o  out  DATA_W  read data from the last read, held
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid while mem_en_o=1 and mem_we_o=0
- busy_o  out  1  state != IDLE
- snoop_valid_o  out  1  see Optional Feature
- snoop_addr_o  out  ADDR_W  see Optional Feature
- snoop_src_o  out  $clog2(N_REQ)  see Optional Feature

Behaviour:
- Reset values: state=IDLE, rr pointer=0, all outputs 0 (including rdata_o). Reset mid-transaction aborts it: no ack, memory outputs drop next cycle.
- FSM states: IDLE, ACCESS, RESP. All outputs registered.
- IDLE: if any unmasked req_i[k]=1, select the first k at or after the pointer, wrapping modulo N_REQ. Latch sel, we, addr and wdata. Next cycle: gnt_o[sel]=1, state ACCESS, cnt=MEM_LAT-1.
- ACCESS: mem_en_o=1 with the latched we/addr/wdata. If cnt==0: capture mem_rdata_i (reads only), go RESP; else cnt--. Requester inputs are ignored during ACCESS.
- RESP: ack_o[sel]=1 for one cycle; rdata_o holds the captured data (unchanged on writes). Pointer ← (sel+1) mod N_REQ; next state IDLE.
- Latency: req seen at edge t gives gnt at t+1, mem_en_o over t+1..t+MEM_LAT, ack at t+MEM_LAT+1. Minimum period between grants is MEM_LAT+2 cycles.
- Post-ack mask: in the IDLE cycle immediately after RESP, req_i[sel] is masked. This prevents a spurious re-grant while the L1 drops req. Other requesters are unaffected.
- If req_i[sel] drops during ACCESS, the access still completes and ack is still issued.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ-1 transactions.
- Counter width is $clog2(MEM_LAT+1). MEM_LAT=1 gives a single ACCESS cycle.

Optional Feature:
- Macro: DMEM_ARB_SNOOP_INV_EN.
- Defined: in the RESP cycle of a write, snoop_valid_o=1, snoop_addr_o=latched addr, snoop_src_o=sel. Other L1s invalidate the matching line. No pulse on reads.
- Undefined: snoop_* tied to 0; no snoop logic synthesized.

Decomposition:
- Shared package cache_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - OPC_LOAD=7'b0000011 and OPC_STORE=7'b0100011
  - default ADDR_W/DATA_W localparams
- One sub-module, rr_arbiter: combinational, taking req vector, mask and pointer, and producing a one-hot grant plus index. The FSM and datapath latches stay in dmem_arbiter.

Test Plan:
- Single read: req_i=01, we=0, addr[0]=0x04C, mem returns 0xDEADBEEF (MEM_LAT=2).
  Expect gnt_o=01 at t+1; mem_en_o high t+1..t+2, addr 0x04C; ack_o=01 at t+3, rdata_o=0xDEADBEEF.
- Contention: req_i=11 at the same edge after reset.
  Expect requester 0 granted first, requester 1 granted in the IDLE after its ack. A third round with both requesting grants 0 again.
- Write: req 1, we=1, addr 0x3FF, wdata 0x12345678.
  Expect mem_we_o=1 with those values, ack_o=10, rdata_o unchanged. With the macro, snoop_valid_o=1, snoop_addr_o=0x3FF, snoop_src_o=1 in the ack cycle.
- Held req: requester 0 keeps req high one cycle after ack, nobody else requesting.
  Expect no second gnt in that cycle; next gnt only on the following IDLE cycle.
- Reset mid-ACCESS: assert reset for one cycle during ACCESS.
  Expect no ack; all outputs 0 next cycle; pointer 0; a new req then gets normal latency.
- MEM_LAT=1 build: single read returns ack at t+2 with mem_en_o high only at t+1.
